// File: rtl/pipe_ctrl_pkg.sv
// Shared control-word layout, NOP/jump encodings and the opcode decode function
// used by the pipeline controller.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 12;

  typedef struct packed {
    logic [2:0] jump_type;
    logic       mem_write;
    logic [3:0] alu_select;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_imm;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
  } dec_t;

  localparam int JT_MSB   = 11;
  localparam int JT_LSB   = 9;
  localparam int MW_BIT   = 8;
  localparam int ALU_MSB  = 7;
  localparam int ALU_LSB  = 4;
  localparam int MR_BIT   = 3;
  localparam int M2R_BIT  = 2;
  localparam int RW_BIT   = 1;
  localparam int IMM_BIT  = 0;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [2:0] JT_NONE = 3'd0;
  localparam logic [2:0] JT_G16  = 3'd1;
  localparam logic [2:0] JT_G17  = 3'd2;
  localparam logic [2:0] JT_G18  = 3'd3;
  localparam logic [2:0] JT_G19  = 3'd4;
  localparam logic [2:0] JT_G20  = 3'd5;
  localparam logic [2:0] JT_G21  = 3'd7;

  localparam logic [3:0] ALU_ADDR  = 4'd5;
  localparam logic [3:0] ALU_UPPER = 4'd8;

  // msb/grp are the top opcode bit and top five bits; val is the whole opcode
  // zero-extended, which for msb=0 is the plain opcode number.
  function automatic dec_t decode_op(input logic msb, input logic [4:0] grp,
                                     input logic [31:0] val);
    dec_t d;
    d.ctrl    = CTRL_NOP;
    d.illegal = 1'b0;
    if (!msb) begin
      if (val == 32'd0) begin
        d.ctrl = CTRL_NOP;
      end else if (val >= 32'd1 && val <= 32'd6) begin
        d.ctrl.alu_select = val[3:0];
        d.ctrl.reg_write  = 1'b1;
      end else if (val >= 32'd8 && val <= 32'd13) begin
        d.ctrl.alu_select = val[3:0] - 4'd7;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_imm    = 1'b1;
      end else if (val == 32'd14) begin
        d.ctrl.alu_select = ALU_ADDR;
        d.ctrl.mem_write  = 1'b1;
        d.ctrl.alu_imm    = 1'b1;
      end else if (val == 32'd15) begin
        d.ctrl.alu_select = ALU_ADDR;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_imm    = 1'b1;
      end else if (val == 32'd16) begin
        d.ctrl.alu_select = ALU_UPPER;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_imm    = 1'b1;
      end else begin
        d.illegal = 1'b1;
      end
    end else begin
      case (grp)
        5'd16:   d.ctrl.jump_type = JT_G16;
        5'd17:   d.ctrl.jump_type = JT_G17;
        5'd18:   d.ctrl.jump_type = JT_G18;
        5'd19:   d.ctrl.jump_type = JT_G19;
        5'd20:   d.ctrl.jump_type = JT_G20;
        5'd21:   d.ctrl.jump_type = JT_G21;
        5'd22: begin
          d.ctrl.alu_select = ALU_ADDR;
          d.ctrl.mem_write  = 1'b1;
          d.ctrl.alu_imm    = 1'b1;
        end
        5'd23: begin
          d.ctrl.alu_select = ALU_ADDR;
          d.ctrl.mem_read   = 1'b1;
          d.ctrl.mem_to_reg = 1'b1;
          d.ctrl.reg_write  = 1'b1;
          d.ctrl.alu_imm    = 1'b1;
        end
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder; every opcode maps to a defined word, unknown
// opcodes give NOP with illegal set.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 10
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o
);

  dec_t dec;

  always_comb begin
    dec = decode_op(opcode_i[OPCODE_W-1], opcode_i[OPCODE_W-1 -: 5], 32'(opcode_i));
  end

  assign ctrl_o    = dec.ctrl;
  assign illegal_o = dec.illegal;

endmodule

// File: rtl/pipe_controller.sv
// Pipeline control: decode into ID/EX, carry control words and rd through
// EX/MEM and MEM/WB, with load-use stall, branch flush and external freeze.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 10,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                ex_branch_taken,
  input  logic                ext_stall,
  output logic                id_stall,
  output logic                if_flush,
  output logic [CTRL_W-1:0]   ex_ctrl,
  output logic [CTRL_W-1:0]   mem_ctrl,
  output logic [CTRL_W-1:0]   wb_ctrl,
  output logic [REG_W-1:0]    ex_rd,
  output logic [REG_W-1:0]    mem_rd,
  output logic [REG_W-1:0]    wb_rd,
  output logic                ex_illegal,
  output logic                illegal_seen,
  output logic [CNT_W-1:0]    stall_count
);

  ctrl_t            dec_ctrl;
  logic             dec_illegal;

  ctrl_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic             ex_ill_q, ex_ill_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_use, lu_stall, bubble;

  ctrl_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode_i  (id_opcode),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // ext_stall outranks the branch flush, which outranks load-use.
  always_comb begin
    load_use = id_valid && ex_q.mem_read && (ex_rd_q != '0) &&
               ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    if_flush = !ext_stall && ex_branch_taken;
    lu_stall = !ext_stall && !ex_branch_taken && load_use;
    id_stall = ext_stall || lu_stall;
    bubble   = if_flush || lu_stall || !id_valid;

    ex_d     = ex_q;
    ex_rd_d  = ex_rd_q;
    ex_ill_d = ex_ill_q;
    mem_d    = mem_q;
    mem_rd_d = mem_rd_q;
    wb_d     = wb_q;
    wb_rd_d  = wb_rd_q;
    if (!ext_stall) begin
      ex_d     = bubble ? CTRL_NOP : dec_ctrl;
      ex_rd_d  = bubble ? '0 : id_rd;
      ex_ill_d = bubble ? 1'b0 : dec_illegal;
      mem_d    = ex_q;
      mem_rd_d = ex_rd_q;
      wb_d     = mem_q;
      wb_rd_d  = mem_rd_q;
    end

    cnt_d  = (lu_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    seen_d = seen_q | ex_ill_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= CTRL_NOP;
      mem_q    <= CTRL_NOP;
      wb_q     <= CTRL_NOP;
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
      ex_ill_q <= 1'b0;
      seen_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      ex_rd_q  <= ex_rd_d;
      mem_rd_q <= mem_rd_d;
      wb_rd_q  <= wb_rd_d;
      ex_ill_q <= ex_ill_d;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_ctrl      = ex_q;
  assign mem_ctrl     = mem_q;
  assign wb_ctrl      = wb_q;
  assign ex_rd        = ex_rd_q;
  assign mem_rd       = mem_rd_q;
  assign wb_rd        = wb_rd_q;
  assign ex_illegal   = ex_ill_q;
  // Visible in the same cycle the illegal word sits in EX, then held.
  assign illegal_seen = seen_q | ex_ill_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: a reference model predicts every
// registered output per cycle and the combinational stall/flush outputs.
module tb_pipe_controller;

  localparam int CW = 5;
  localparam logic [9:0] LOAD_OP = 10'b10111_00000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid = 1'b0;
  logic [9:0]    id_opcode = '0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          ex_branch_taken = 1'b0, ext_stall = 1'b0;
  logic          id_stall, if_flush, ex_illegal, illegal_seen;
  logic [11:0]   ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]    ex_rd, mem_rd, wb_rd;
  logic [CW-1:0] stall_count;

  pipe_controller #(.OPCODE_W(10), .REG_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .id_stall(id_stall), .if_flush(if_flush),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_illegal(ex_illegal), .illegal_seen(illegal_seen), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]   ex, mem, wb;
    logic [4:0]    exrd, memrd, wbrd;
    logic          ill, seen;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];

  logic [11:0]   m_ex, m_mem, m_wb;
  logic [4:0]    m_exrd, m_memrd, m_wbrd;
  logic          m_ill, m_seen;
  logic [CW-1:0] m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, control word}.
  function automatic logic [12:0] ref_dec(input logic [9:0] op);
    logic [4:0] g;
    g = op[9:5];
    if (!op[9]) begin
      if (op == 10'd0)                    return 13'h0000;
      if (op >= 10'd1 && op <= 10'd6)     return {1'b0, 12'h002 | (12'(op[3:0]) << 4)};
      if (op >= 10'd8 && op <= 10'd13)    return {1'b0, 12'h003 | (12'(op[3:0] - 4'd7) << 4)};
      if (op == 10'd14)                   return {1'b0, 12'h151};
      if (op == 10'd15)                   return {1'b0, 12'h05F};
      if (op == 10'd16)                   return {1'b0, 12'h083};
      return 13'h1000;
    end
    case (g)
      5'd16: return {1'b0, 12'h200};
      5'd17: return {1'b0, 12'h400};
      5'd18: return {1'b0, 12'h600};
      5'd19: return {1'b0, 12'h800};
      5'd20: return {1'b0, 12'hA00};
      5'd21: return {1'b0, 12'hE00};
      5'd22: return {1'b0, 12'h151};
      5'd23: return {1'b0, 12'h05F};
      default: return 13'h1000;
    endcase
  endfunction

  task automatic model_clear();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_exrd = '0; m_memrd = '0; m_wbrd = '0;
    m_ill = 1'b0; m_seen = 1'b0; m_cnt = '0;
    sbq.delete();
  endtask

  // Entered and left at posedge+1.
  task automatic step(input logic v, input logic [9:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      input logic br, input logic xs);
    logic [12:0] d;
    logic        lu, bub;
    exp_t        e;
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    ex_branch_taken = br; ext_stall = xs;
    #1;
    lu = v && m_ex[3] && (m_exrd != 5'd0) && ((m_exrd == rs1) || (m_exrd == rs2));
    chk("id_stall", 32'(id_stall), 32'(xs || (!br && lu)));
    chk("if_flush", 32'(if_flush), 32'(!xs && br));
    m_seen = m_seen | m_ill;
    if (!xs) begin
      bub = br || lu || !v;
      d = ref_dec(op);
      m_wb = m_mem; m_wbrd = m_memrd;
      m_mem = m_ex; m_memrd = m_exrd;
      m_ex = bub ? 12'h000 : d[11:0];
      m_exrd = bub ? 5'd0 : rd;
      m_ill = bub ? 1'b0 : d[12];
      if (!br && lu && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + 1'b1;
    end
    e.ex = m_ex; e.mem = m_mem; e.wb = m_wb;
    e.exrd = m_exrd; e.memrd = m_memrd; e.wbrd = m_wbrd;
    e.ill = m_ill; e.seen = m_seen | m_ill; e.cnt = m_cnt;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ex));
    chk("mem_ctrl", 32'(mem_ctrl), 32'(e.mem));
    chk("wb_ctrl", 32'(wb_ctrl), 32'(e.wb));
    chk("ex_rd", 32'(ex_rd), 32'(e.exrd));
    chk("mem_rd", 32'(mem_rd), 32'(e.memrd));
    chk("wb_rd", 32'(wb_rd), 32'(e.wbrd));
    chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
    chk("illegal_seen", 32'(illegal_seen), 32'(e.seen));
    chk("stall_count", 32'(stall_count), 32'(e.cnt));
  endtask

  // Asserts reset with whatever inputs are currently applied; releases at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("rst_mem_ctrl", 32'(mem_ctrl), 32'h0);
    chk("rst_wb_ctrl", 32'(wb_ctrl), 32'h0);
    chk("rst_rd", 32'({ex_rd, mem_rd, wb_rd}), 32'h0);
    chk("rst_ex_illegal", 32'(ex_illegal), 32'h0);
    chk("rst_illegal_seen", 32'(illegal_seen), 32'h0);
    chk("rst_stall_count", 32'(stall_count), 32'h0);
    model_clear();
    id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    ex_branch_taken = 1'b0; ext_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] op;
    #1;
    do_reset();

    // Single instruction walks EX -> MEM -> WB, zeros elsewhere.
    step(1'b1, 10'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Opcode sweep, low space and every high group.
    for (int i = 0; i < 24; i++) step(1'b1, 10'(i), 5'd7, 5'd8, 5'(i % 8), 1'b0, 1'b0);
    for (int g = 16; g < 32; g++) step(1'b1, {5'(g), 5'(g)}, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0);
    repeat (3) step(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Load-use stall, rd=0 non-stall, branch over load-use.
    do_reset();
    step(1'b1, LOAD_OP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step(1'b1, 10'd1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
    chk("lu_bubble_ex", 32'(ex_ctrl), 32'h0);
    chk("lu_count", 32'(stall_count), 32'd1);
    step(1'b1, 10'd1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
    chk("lu_released_ex", 32'(ex_ctrl), 32'h012);
    step(1'b1, LOAD_OP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 10'd1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
    chk("rd0_count", 32'(stall_count), 32'd1);
    step(1'b1, LOAD_OP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step(1'b1, 10'd1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0);
    chk("br_lu_ex", 32'(ex_ctrl), 32'h0);

    // Reset while frozen, flushing and with a load in EX leaves no stall behind.
    step(1'b1, LOAD_OP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    id_valid = 1'b1; id_rs1 = 5'd3; ext_stall = 1'b1; ex_branch_taken = 1'b1;
    do_reset();
    step(1'b1, 10'd1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);

    // Freeze with a full pipe for three cycles, then resume.
    step(1'b1, 10'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    step(1'b1, 10'd2, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    step(1'b1, 10'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    repeat (3) step(1'b1, 10'd4, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1);
    step(1'b1, 10'd4, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    repeat (3) step(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Illegal opcodes and sticky flag.
    do_reset();
    step(1'b1, 10'd7, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    chk("ill7_flag", 32'(ex_illegal), 32'd1);
    step(1'b1, 10'b11111_00000, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    chk("ill31_ctrl", 32'(ex_ctrl), 32'h0);
    repeat (4) step(1'b1, 10'd2, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    chk("ill_sticky", 32'(illegal_seen), 32'd1);
    do_reset();

    // Counter saturation.
    repeat (40) begin
      step(1'b1, LOAD_OP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      step(1'b1, 10'd1, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
    end
    chk("cnt_saturated", 32'(stall_count), 32'd31);

    // Random mix with frequent hazards.
    do_reset();
    repeat (300) begin
      case ($urandom_range(0, 3))
        0:       op = 10'($urandom_range(0, 17));
        1:       op = {5'($urandom_range(16, 31)), 5'($urandom_range(0, 31))};
        2:       op = LOAD_OP;
        default: op = 10'($urandom_range(0, 1023));
      endcase
      step($urandom_range(0, 7) != 0, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameters: OPCODE_W 10, opcode width; REG_W 5, register-address width; CNT_W 16, stall-counter width; control word fixed at 12 bits.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 id_valid  in  1  ID slot holds a real instruction.
REQ-005 id_opcode  in  OPCODE_W  opcode of the ID instruction.
REQ-006 id_rs1, id_rs2, id_rd  in  REG_W each  source and destination registers of the ID instruction.
REQ-007 ex_branch_taken  in  1  EX resolved a taken jump this cycle.
REQ-008 ext_stall  in  1  memory busy; freeze the whole pipe.
REQ-009 id_stall  out  1  hold PC and IF/ID this cycle (combinational).
REQ-010 if_flush  out  1  squash IF/ID this cycle (combinational).
REQ-011 ex_ctrl, mem_ctrl, wb_ctrl  out  12 each  control word in EX, MEM, WB; bits {jump_type[2:0], mem_write, alu_select[3:0], mem_read, mem_to_reg, reg_write, alu_imm}.
REQ-012 ex_illegal  out  1  instruction in EX decoded as illegal.
REQ-013 illegal_seen  out  1  sticky: any illegal opcode has reached EX.
REQ-014 stall_count  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-015 Decode SHALL be combinational and complete; no latch on any opcode.
REQ-016 If opcode[OPCODE_W-1]=0: defined values are 0-6 and 8-16; 0 decodes to the all-zero word (NOP).
REQ-017 If opcode[OPCODE_W-1]=1: opcode[OPCODE_W-1:OPCODE_W-5] selects the group; defined groups are 16-23. Groups 16-21 are jumps with jump_type 1,2,3,4,5,7; group 23 is a load: alu_select 5, mem_read, mem_to_reg, reg_write, alu_imm.
REQ-018 Every other opcode SHALL decode to NOP with illegal=1.
REQ-019 Stages: ID/EX, EX/MEM, MEM/WB registers. A word decoded at cycle n appears on ex_ctrl at n+1, mem_ctrl at n+2 and wb_ctrl at n+3, provided no stall or flush intervenes.
REQ-020 id_valid=0 SHALL inject NOP into ID/EX.
REQ-021 Load-use: id_valid=1, ID/EX mem_read=1, ID/EX rd!=0, and ID/EX rd equal to id_rs1 or id_rs2.
REQ-022 On load-use: id_stall=1, NOP into ID/EX, EX/MEM and MEM/WB advance normally.
REQ-023 ex_branch_taken=1 SHALL give if_flush=1, NOP into ID/EX, id_stall=0.
REQ-024 ext_stall=1 SHALL hold all three stage registers and stall_count, with id_stall=1 and if_flush=0.
REQ-025 Priority: ext_stall > ex_branch_taken > load-use; a lower event is suppressed in that cycle and re-evaluated next cycle.
REQ-026 stall_count SHALL increment by 1 per load-use stall cycle and saturate at all-ones.
REQ-027 illegal_seen SHALL set when ex_illegal=1 and clear only on reset.
REQ-028 The rd of each stage SHALL be carried alongside its control word.

Reset
REQ-029 While rst_n=0: all stage words NOP, all carried rd 0, ex_illegal 0, illegal_seen 0, stall_count 0.
REQ-030 Reset asserted mid-stall or mid-flush SHALL clear immediately, with no residual stall on the first cycle after release.

Structure
REQ-031 Shared package pipe_ctrl_pkg SHALL hold the 12-bit control-word struct, the field positions, the NOP constant, the jump_type codes and the decode function.
REQ-032 A single sub-module ctrl_decode SHALL hold the combinational decoder; the hazard, flush and stage logic stay in pipe_controller.

Verification
REQ-033 Reset then id_opcode=1, id_valid=1 for one cycle, then NOP -> the word appears on ex_ctrl at +1, mem_ctrl at +2, wb_ctrl at +3; every other cycle shows 0.
REQ-034 Load group 23 with rd=3, next ID rs1=3 -> id_stall=1 for exactly 1 cycle, ex_ctrl=0 in the bubble cycle, stall_count=1.
REQ-035 Same as REQ-034 but rd=0 -> no stall.
REQ-036 ex_branch_taken=1 together with load-use -> if_flush=1, id_stall=0, ID/EX=NOP.
REQ-037 ext_stall held 3 cycles with the pipe full -> ex_ctrl, mem_ctrl and wb_ctrl are unchanged for all 3 cycles and resume correctly afterwards.
REQ-038 Opcode 7, then opcode 10'b11111_00000 -> ex_illegal=1 with ex_ctrl=0 for each; illegal_seen stays 1 until rst_n=0.
